// File: rtl/tick_slot_sequencer_pkg.sv
// Shared types and packet field helpers for the tick slot sequencer.
// Field helpers work on a wide container so any module width can use them.
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_e;

  localparam int DROP_CNT_W = 16;
  localparam int MAX_PKT_W = 64;
  localparam int GRANULARITY_DEF = 4;

  typedef logic [$clog2(GRANULARITY_DEF)-1:0] slot_idx_t;
  typedef logic [MAX_PKT_W-1:0] pkt_word_t;

  // Delay sits in the top dly_w bits of a pkt_w wide packet.
  function automatic pkt_word_t pkt_delay(
    input pkt_word_t   pkt,
    input int unsigned pkt_w,
    input int unsigned dly_w
  );
    pkt_word_t mask;
    mask = ~pkt_word_t'(0) >> (MAX_PKT_W - dly_w);
    return (pkt >> (pkt_w - dly_w)) & mask;
  endfunction

  function automatic pkt_word_t pkt_payload(
    input pkt_word_t   pkt,
    input int unsigned pay_w
  );
    pkt_word_t mask;
    mask = ~pkt_word_t'(0) >> (MAX_PKT_W - pay_w);
    return pkt & mask;
  endfunction

endpackage

// File: rtl/tick_slot_sequencer_if.sv
// Router, slot FIFO array and neuron controller signals of the sequencer.
// master is the sequencer side, slave the surrounding scheduler.
interface tick_slot_sequencer_if
  import sched_pkg::*;
#(
  parameter int GRANULARITY = 4,
  parameter int PKT_SIZE    = 32
) ();

  localparam int DELAY_W   = $clog2(GRANULARITY);
  localparam int PAYLOAD_W = PKT_SIZE - DELAY_W;

  logic                             tick;
  logic                             in_valid;
  logic                             in_ready;
  logic [PKT_SIZE-1:0]              in_packet;
  logic [GRANULARITY-1:0]           slot_wr_en;
  logic [PAYLOAD_W-1:0]             slot_wr_data;
  logic [GRANULARITY-1:0]           slot_full;
  logic [GRANULARITY-1:0]           slot_empty;
  logic [GRANULARITY-1:0]           slot_rd_en;
  logic [GRANULARITY*PAYLOAD_W-1:0] slot_rd_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [PAYLOAD_W-1:0]             out_payload;
  logic                             drain_done;
  logic                             tick_overrun;
  logic [DROP_CNT_W-1:0]            drop_cnt;

  modport master (
    input  tick,
    input  in_valid,
    input  in_packet,
    input  slot_full,
    input  slot_empty,
    input  slot_rd_data,
    input  out_ready,
    output in_ready,
    output slot_wr_en,
    output slot_wr_data,
    output slot_rd_en,
    output out_valid,
    output out_payload,
    output drain_done,
    output tick_overrun,
    output drop_cnt
  );

  modport slave (
    output tick,
    output in_valid,
    output in_packet,
    output slot_full,
    output slot_empty,
    output slot_rd_data,
    output out_ready,
    input  in_ready,
    input  slot_wr_en,
    input  slot_wr_data,
    input  slot_rd_en,
    input  out_valid,
    input  out_payload,
    input  drain_done,
    input  tick_overrun,
    input  drop_cnt
  );

endinterface

// File: rtl/tick_slot_sequencer.sv
// Steers router packets into per-tick slot FIFOs and drains the
// current slot to the neuron controller on every global tick.
module tick_slot_sequencer
  import sched_pkg::*;
#(
  parameter int GRANULARITY = 4,
  parameter int PKT_SIZE    = 32
) (
  input logic                  clk,
  input logic                  rst,
  tick_slot_sequencer_if.master bus
);

  localparam int DELAY_W   = $clog2(GRANULARITY);
  localparam int PAYLOAD_W = PKT_SIZE - DELAY_W;

  typedef logic [DELAY_W-1:0] slot_t;

  state_e                state;
  state_e                state_nx;
  slot_t                 cur_slot;
  slot_t                 cur_slot_nx;
  logic                  tick_pend;
  logic                  tick_pend_nx;
  logic                  overrun;
  logic                  overrun_nx;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic [DROP_CNT_W-1:0] drop_nx;

  pkt_word_t             pkt_ext;
  slot_t                 dly;
  slot_t                 target;
  logic                  illegal;
  logic [PAYLOAD_W-1:0]  payload;
  logic [PAYLOAD_W-1:0]  head;

  logic                   in_ready;
  logic [GRANULARITY-1:0] wr_en;
  logic                   out_valid;
  logic [PAYLOAD_W-1:0]   out_payload;
  logic [GRANULARITY-1:0] rd_en;
  logic                   drain_done;

  always_comb begin
    pkt_ext = pkt_word_t'(bus.in_packet);
    dly     = slot_t'(pkt_delay(pkt_ext, PKT_SIZE, DELAY_W));
    payload = PAYLOAD_W'(pkt_payload(pkt_ext, PAYLOAD_W));
    target  = cur_slot + dly;
    illegal = (dly == '0);
    head    = bus.slot_rd_data[int'(cur_slot)*PAYLOAD_W +: PAYLOAD_W];
  end

  // Zero delay would land in the slot being drained: consume and count it.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = '0;
    drop_nx  = drop_cnt;
    if (!rst) begin
      in_ready = illegal | !bus.slot_full[target];
      if (bus.in_valid & in_ready & !illegal)
        wr_en[target] = 1'b1;
      if (bus.in_valid & illegal & (drop_cnt != '1))
        drop_nx = drop_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx     = state;
    cur_slot_nx  = cur_slot;
    tick_pend_nx = tick_pend;
    overrun_nx   = overrun;
    out_valid    = 1'b0;
    out_payload  = '0;
    rd_en        = '0;
    drain_done   = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (bus.tick | tick_pend) begin
            state_nx     = DRAIN;
            cur_slot_nx  = cur_slot + 1'b1;
            tick_pend_nx = tick_pend & bus.tick;
          end
        end
        DRAIN: begin
          out_valid       = !bus.slot_empty[cur_slot];
          out_payload     = head;
          rd_en[cur_slot] = out_valid & bus.out_ready;
          if (bus.slot_empty[cur_slot])
            state_nx = DONE;
        end
        DONE: begin
          drain_done = 1'b1;
          state_nx   = IDLE;
        end
        default: state_nx = IDLE;
      endcase
      // One tick can wait behind a busy drain; a second one is lost.
      if ((state != IDLE) & bus.tick) begin
        if (!tick_pend)
          tick_pend_nx = 1'b1;
        else
          overrun_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_slot  <= '0;
      tick_pend <= 1'b0;
      overrun   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nx;
      cur_slot  <= cur_slot_nx;
      tick_pend <= tick_pend_nx;
      overrun   <= overrun_nx;
      drop_cnt  <= drop_nx;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.slot_wr_en   = wr_en;
  assign bus.slot_wr_data = payload;
  assign bus.slot_rd_en   = rd_en;
  assign bus.out_valid    = out_valid;
  assign bus.out_payload  = out_payload;
  assign bus.drain_done   = drain_done;
  assign bus.tick_overrun = overrun;
  assign bus.drop_cnt     = drop_cnt;

endmodule

// File: tb/tb_tick_slot_sequencer.sv
// Bench for tick_slot_sequencer: queue-based slot FIFOs plus a
// tick-accounting reference model checked every cycle.
module tb_tick_slot_sequencer;

  localparam int G   = 4;
  localparam int PW  = 30;
  localparam int CAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_slot_sequencer_if #(.GRANULARITY(G), .PKT_SIZE(32)) bus ();

  tick_slot_sequencer #(.GRANULARITY(G), .PKT_SIZE(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [PW-1:0] q[G][$];
  logic [PW-1:0] popped[$];
  logic [G-1:0]  force_full;

  // Model: logical tick slot, drain phase (0 idle, 1 draining, 2 done),
  // one owed tick, lost-tick flag and drop count.
  int m_cur;
  int m_phase;
  bit m_pend;
  bit m_ovr;
  int m_drop;

  int a_tgt;
  bit a_wr;
  bit a_rd;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int d, input logic [29:0] p);
    return {d[1:0], p};
  endfunction

  task automatic drive_slots();
    for (int i = 0; i < G; i++) begin
      bus.slot_full[i]  = (q[i].size() >= CAP) || force_full[i];
      bus.slot_empty[i] = (q[i].size() == 0);
      bus.slot_rd_data[i*PW +: PW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  task automatic check();
    int d;
    int tgt;
    bit e_ready;
    bit e_ov;
    bit e_done;
    logic [G-1:0] e_wr;
    logic [G-1:0] e_rd;
    d = int'(bus.in_packet[31:30]);
    tgt = (m_cur + d) % G;
    e_ready = 1'b0;
    e_ov = 1'b0;
    e_done = 1'b0;
    e_wr = '0;
    e_rd = '0;
    a_wr = 1'b0;
    a_rd = 1'b0;
    if (!rst) begin
      e_ready = (d == 0) || (q[tgt].size() < CAP && !force_full[tgt]);
      a_wr = bus.in_valid && e_ready && (d != 0);
      if (a_wr) e_wr[tgt] = 1'b1;
      e_ov = (m_phase == 1) && (q[m_cur].size() > 0);
      a_rd = e_ov && bus.out_ready;
      if (a_rd) e_rd[m_cur] = 1'b1;
      e_done = (m_phase == 2);
    end
    a_tgt = tgt;
    chk("in_ready", 32'(bus.in_ready), 32'(e_ready));
    chk("slot_wr_en", 32'(bus.slot_wr_en), 32'(e_wr));
    if (a_wr)
      chk("slot_wr_data", 32'(bus.slot_wr_data), 32'(bus.in_packet[29:0]));
    chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
    if (e_ov)
      chk("out_payload", 32'(bus.out_payload), 32'(q[m_cur][0]));
    chk("slot_rd_en", 32'(bus.slot_rd_en), 32'(e_rd));
    chk("drain_done", 32'(bus.drain_done), 32'(e_done));
    chk("tick_overrun", 32'(bus.tick_overrun), 32'(m_ovr));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    if (a_rd) popped.push_back(q[m_cur][0]);
  endtask

  task automatic advance();
    bit drained;
    if (rst) begin
      for (int i = 0; i < G; i++) q[i].delete();
      m_cur = 0;
      m_phase = 0;
      m_pend = 1'b0;
      m_ovr = 1'b0;
      m_drop = 0;
      return;
    end
    drained = (m_phase == 1) && (q[m_cur].size() == 0);
    if (a_rd) void'(q[m_cur].pop_front());
    if (a_wr) q[a_tgt].push_back(bus.in_packet[PW-1:0]);
    if (bus.in_valid && bus.in_packet[31:30] == 2'd0 && m_drop < 65535)
      m_drop++;
    if (m_phase == 0) begin
      if (m_pend || bus.tick) begin
        m_cur = (m_cur + 1) % G;
        m_phase = 1;
        m_pend = m_pend && bus.tick;
      end
    end else begin
      if (bus.tick) begin
        if (m_pend) m_ovr = 1'b1;
        else m_pend = 1'b1;
      end
      m_phase = (m_phase == 2) ? 0 : (drained ? 2 : 1);
    end
  endtask

  task automatic step(input bit t, input bit iv, input logic [31:0] pkt,
                      input bit ordy);
    bus.tick = t;
    bus.in_valid = iv;
    bus.in_packet = pkt;
    bus.out_ready = ordy;
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    advance();
    drive_slots();
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) step(1'b0, 1'b0, 32'h0, ordy);
  endtask

  initial begin
    int n0;
    force_full = '0;
    m_cur = 0;
    m_phase = 0;
    m_pend = 1'b0;
    m_ovr = 1'b0;
    m_drop = 0;
    bus.tick = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_packet = '0;
    bus.out_ready = 1'b0;
    drive_slots();
    @(posedge clk);
    #1;
    idle(2, 1'b0);
    rst = 1'b0;
    chk("reset_drop", 32'(bus.drop_cnt), 32'h0);
    chk("reset_ovr", 32'(bus.tick_overrun), 32'h0);

    // routing and drain order
    step(1'b0, 1'b1, pk(1, 30'hA), 1'b1);
    step(1'b0, 1'b1, pk(2, 30'hB), 1'b1);
    step(1'b0, 1'b1, pk(1, 30'hC), 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(6, 1'b1);
    chk("route_cnt1", 32'(popped.size()), 32'd2);
    chk("route_p0", 32'(popped[0]), 32'hA);
    chk("route_p1", 32'(popped[1]), 32'hC);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(6, 1'b1);
    chk("route_cnt2", 32'(popped.size()), 32'd3);
    chk("route_p2", 32'(popped[2]), 32'hB);

    // empty slot: drain_done two cycles after the tick
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("empty_done", 32'(bus.drain_done), 32'h1);
    idle(2, 1'b1);

    // backpressure on a full target, then a held drain
    force_full = 4'b0001;
    drive_slots();
    step(1'b0, 1'b1, pk(1, 30'h11), 1'b1);
    force_full = '0;
    drive_slots();
    step(1'b0, 1'b1, pk(1, 30'h11), 1'b1);
    step(1'b0, 1'b1, pk(1, 30'h12), 1'b1);
    n0 = popped.size();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    idle(5, 1'b0);
    chk("hold_nopop", 32'(popped.size()), 32'(n0));
    chk("hold_valid", 32'(bus.out_valid), 32'h1);
    chk("hold_payload", 32'(bus.out_payload), 32'h11);
    idle(6, 1'b1);
    chk("bp_p0", 32'(popped[n0]), 32'h11);
    chk("bp_p1", 32'(popped[n0+1]), 32'h12);

    // illegal zero delay
    step(1'b0, 1'b1, pk(0, 30'h21), 1'b1);
    step(1'b0, 1'b1, pk(0, 30'h22), 1'b1);
    step(1'b0, 1'b1, pk(0, 30'h23), 1'b1);
    chk("drop3", 32'(bus.drop_cnt), 32'd3);

    // tick overrun during a stalled drain: slot advances by two in total
    step(1'b0, 1'b1, pk(1, 30'h31), 1'b1);
    step(1'b0, 1'b1, pk(1, 30'h32), 1'b1);
    step(1'b0, 1'b1, pk(1, 30'h33), 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    idle(1, 1'b0);
    chk("ovr_before", 32'(bus.tick_overrun), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("ovr_set", 32'(bus.tick_overrun), 32'h1);
    idle(12, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_packet = pk(1, 30'h55);
    #1;
    chk("ovr_target", 32'(bus.slot_wr_en), 32'b1000);
    step(1'b0, 1'b1, pk(1, 30'h55), 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 12) == 0, $urandom % 2,
           pk(int'($urandom % 4), 30'($urandom)), ($urandom % 3) != 0);
    end
    idle(20, 1'b1);

    // drop counter saturation
    repeat (65540) step(1'b0, 1'b1, pk(0, 30'($urandom)), 1'b1);
    chk("drop_sat", 32'(bus.drop_cnt), 32'hFFFF);

    // reset mid-drain with a pending tick
    step(1'b0, 1'b1, pk(1, 30'h41), 1'b1);
    step(1'b0, 1'b1, pk(1, 30'h42), 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    chk("rst_ovr", 32'(bus.tick_overrun), 32'h0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 1'b1;
    bus.in_packet = pk(1, 30'h66);
    #1;
    chk("rst_target", 32'(bus.slot_wr_en), 32'b0010);
    step(1'b0, 1'b1, pk(1, 30'h66), 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tick_slot_sequencer.md
Name: tick_slot_sequencer

Overview:
Control engine for the scheduler's per-tick slot FIFOs (GRANULARITY slots, one per future tick).
- Ingress side: steers each router packet into slot (cur_slot + delay) mod GRANULARITY, with valid/ready backpressure.
- Egress side: on every global tick, advances the current-slot pointer and drains that slot to the neuron controller over a valid/ready handshake.
- Sits between the router and the slot FIFO array. The FIFOs are external, show-ahead (FWFT), one per slot, and share clk/rst.

Parameters:
GRANULARITY, 4, number of tick slots; power of two, >= 2
PKT_SIZE, 32, router packet width
DELAY_W, $clog2(GRANULARITY), delay field width, packet bits [PKT_SIZE-1 -: DELAY_W]
PAYLOAD_W, PKT_SIZE-DELAY_W, payload width (packet low bits)

Ports:
clk  in  1  local clock
rst  in  1  synchronous active-high reset
tick  in  1  global tick, single-cycle pulse
in_valid  in  1  router packet valid
in_ready  out  1  sequencer accepts packet this cycle
in_packet  in  PKT_SIZE  {delay, payload}
slot_wr_en  out  GRANULARITY  one-hot push to slot FIFO
slot_wr_data  out  PAYLOAD_W  payload to push (shared by all slots)
slot_full  in  GRANULARITY  per-slot full
slot_empty  in  GRANULARITY  per-slot empty
slot_rd_en  out  GRANULARITY  one-hot pop
slot_rd_data  in  GRANULARITY*PAYLOAD_W  per-slot head word, slot i at [i*PAYLOAD_W +: PAYLOAD_W]
out_valid  out  1  payload to controller valid
out_ready  in  1  controller accepts
out_payload  out  PAYLOAD_W  head of current slot
drain_done  out  1  one-cycle pulse when the current slot is empty after a tick
tick_overrun  out  1  sticky flag; tick lost
drop_cnt  out  16  saturating count of dropped packets

Behaviour:
- Reset values: cur_slot=0, state=IDLE, tick_pend=0. All outputs 0: in_ready, out_valid, slot_wr_en, slot_rd_en, drain_done, tick_overrun, drop_cnt.
- FSM states and transitions:
  - IDLE -(tick or tick_pend)-> DRAIN: cur_slot <= cur_slot+1 (wraps mod GRANULARITY); tick_pend <= 0.
  - DRAIN: out_valid = !slot_empty[cur_slot]; out_payload = slot_rd_data[cur_slot]; slot_rd_en[cur_slot] = out_valid & out_ready (combinational).
  - DRAIN -(slot_empty[cur_slot] & !out_valid)-> DONE.
  - DONE: drain_done=1 for exactly one cycle -> IDLE. A pending tick is serviced on the next cycle.
- Latency: tick at cycle N -> DRAIN at N+1, out_valid at N+1 if the slot is non-empty. An empty slot gives drain_done at N+2.
- Tick while state != IDLE:
  - If tick_pend=0: set tick_pend.
  - Else: tick lost, tick_overrun <= 1 (sticky until rst), cur_slot not advanced for it.
- Tick in the same cycle as the DONE->IDLE transition: set tick_pend; serviced from IDLE next cycle.
- Ingress:
  - d = in_packet[PKT_SIZE-1 -: DELAY_W]; target = (cur_slot + d) mod GRANULARITY (DELAY_W-bit add, natural wrap).
  - d==0 (a delivery into the slot currently draining) is illegal: in_ready=1, packet consumed, no push, drop_cnt += 1 (saturates at 16'hFFFF).
  - d!=0: in_ready = !slot_full[target]. On in_valid & in_ready, slot_wr_en[target]=1, slot_wr_data=payload, same cycle.
  - Full target back-pressures; the packet is never dropped.
- Ingress and egress run concurrently. target never equals cur_slot for a legal packet, so no same-slot push/pop.
- cur_slot is the logical tick. While tick_pend=1, ingress uses the not-yet-advanced cur_slot.
- in_ready is combinational from slot_full and in_packet. A registered variant is out of scope.
- Reset mid-drain or with tick_pend set: everything returns to reset values next cycle. External FIFOs clear on the same rst.
- Invariants:
  - At most one bit set in each of slot_wr_en and slot_rd_en.
  - slot_rd_en only in DRAIN.

Decomposition:
- Package sched_pkg:
  - typedef enum state_e {IDLE, DRAIN, DONE}
  - DROP_CNT_W=16
  - functions pkt_delay() and pkt_payload() for field extraction, parameterised via module localparams
  - slot index typedef sized $clog2(GRANULARITY)
- Single module; no sub-module needed. The slot FIFO array is instantiated alongside by the scheduler top, not inside this block.

Test Plan:
- Routing and drain order, GRANULARITY=4, cur_slot=0: push payloads 0xA (d=1), 0xB (d=2), 0xC (d=1), then tick -> out_payload 0xA then 0xC, then drain_done. Next tick -> 0xB, then drain_done.
- Empty slot: tick with all slots empty -> out_valid never high, drain_done at tick+2 cycles, cur_slot=1.
- Backpressure: slot 1 full, in d=1 -> in_ready=0, no slot_wr_en. Deassert full -> push occurs that cycle. During DRAIN, hold out_ready=0 for 5 cycles -> out_valid held, payload stable, no pop.
- Illegal delay: 3 packets with d=0 -> in_ready=1, no pushes, drop_cnt=3. Force 65536+ drops -> drop_cnt=16'hFFFF.
- Tick overrun: during a long drain (out_ready=0), tick twice -> first sets tick_pend; second sets tick_overrun=1. After drain completes -> IDLE, then immediately DRAIN of next slot; cur_slot advances by exactly 2 in total.
- Reset mid-drain with tick_pend=1 -> next cycle: state IDLE, cur_slot=0, outputs zero, tick_overrun=0, drop_cnt=0.
